cordic_phase_scheduler: RTL and testbench
=========================================

# cordic_phase_scheduler

Shares one iterative CORDIC phase engine between NUM_CH lock-in demodulator channels. Each channel delivers a (sin, cos) pair with a one-cycle valid pulse. The block holds it in a per-channel pending slot, then grants the engine round-robin. It drives the engine's start/operand inputs, waits for its done pulse, and returns the phase tagged with the channel index. It sits between the demodulator bank and the phase-output/telemetry path.

## Interface
- NUM_CH, 4, number of requesting channels (2..8)
- BIT_WIDTH_IN, 24, sin/cos width (signed)
- BIT_WIDTH_OUT, 26, phase width (signed)
- TIMEOUT_CYCLES, 64, max cycles in WAIT before abort (must exceed engine latency)
- clk_i  in  1  clock; single clock domain
- reset_i  in  1  synchronous, active-high reset
- valid_i  in  NUM_CH  per-channel sample strobe
- sin_i  in  NUM_CH*BIT_WIDTH_IN  packed sines; channel k at bits [k*BIT_WIDTH_IN +: BIT_WIDTH_IN]
- cos_i  in  NUM_CH*BIT_WIDTH_IN  packed cosines, same packing
- clear_flags_i  in  1  clears overrun_o and timeout_o
- eng_start_o  out  1  one-cycle start pulse to the engine
- eng_sin_o, eng_cos_o  out  BIT_WIDTH_IN each  operands, held stable from ISSUE until the next grant
- eng_phi_i  in  BIT_WIDTH_OUT  engine phase result
- eng_done_i  in  1  engine result-valid pulse
- phi_o  out  BIT_WIDTH_OUT  phase of the last completed sample
- ch_o  out  $clog2(NUM_CH)  channel index of phi_o
- valid_o  out  1  one-cycle strobe, phi_o/ch_o valid
- busy_o  out  1  high in ISSUE and WAIT
- overrun_o  out  NUM_CH  sticky: sample overwritten before it was granted
- timeout_o  out  1  sticky: engine failed to assert done within TIMEOUT_CYCLES

## Operation
- Pending slots: pend[k], sin_h[k], cos_h[k].
  - valid_i[k] loads the holding registers and sets pend[k].
  - If pend[k] was already set and is not cleared by a grant in the same cycle, the old sample is overwritten and overrun_o[k] is set.
- A grant clears pend[k] on the IDLE→ISSUE edge. If valid_i[k] arrives in the same cycle as the grant, the new sample stays pending (set wins), with no overrun, and the granted operands are the old values.
- Round-robin arbitration:
  - Search starts at last_grant+1 mod NUM_CH; the lowest-index pending channel in that rotated order wins.
  - last_grant resets to NUM_CH-1, so channel 0 has first priority after reset.
- FSM states:
  - IDLE: if any pend, latch winner's sin_h/cos_h into eng_sin_o/eng_cos_o, record grant, update last_grant → ISSUE. Otherwise stay.
  - ISSUE: eng_start_o=1 for exactly this cycle; clear wait counter → WAIT.
  - WAIT: counter increments each cycle.
    - eng_done_i: capture eng_phi_i into phi_o and grant into ch_o → OUTPUT.
    - Counter reaches TIMEOUT_CYCLES-1 without done: set timeout_o, drop the sample, leave phi_o unchanged → IDLE.
  - OUTPUT: valid_o=1 → IDLE.
- eng_done_i outside WAIT is ignored.
- clear_flags_i clears the sticky flags. A flag event in the same cycle wins, so the flag stays set.
- Reset values:
  - State IDLE; pend all 0; last_grant NUM_CH-1.
  - Outputs: eng_start_o 0, eng_sin_o 0, eng_cos_o 0, phi_o 0, ch_o 0, valid_o 0, busy_o 0, overrun_o 0, timeout_o 0.
- Reset mid-WAIT abandons the transaction. The engine has its own reset on the same reset_i.

## Timing
- Sample at cycle t with FSM idle:
  - pend visible at t+1 (IDLE decision in t+1).
  - eng_start_o high at t+2.
- eng_done_i at cycle D → valid_o at D+1; next eng_start_o no earlier than D+3.
- Service time per sample: engine latency + 3 cycles (IDLE, ISSUE, OUTPUT).
- Back-to-back grants are separated by at least one IDLE cycle, which guarantees the engine has returned to idle before the next start.
- Outputs are registered; there is no combinational path from input to output.

## Test plan
- Single request: channel 2 gets sin=0, cos=+4194304 at t=0, with a behavioral engine of latency 26 returning 0x12345.
  - Required: eng_start_o at t=2; eng_sin_o=0 and eng_cos_o=4194304 at start; valid_o at t=29 with phi_o=0x12345, ch_o=2.
- Round-robin fairness: all four channels pulse valid in the same cycle.
  - Required: grant order 0,1,2,3, exactly four valid_o strobes, no overrun.
  - A second burst then re-pulses all four; required order 0,1,2,3 again, starting from last_grant=3.
- Overrun: channel 1 pulses twice (values A then B) while channel 0 is in WAIT.
  - Required: overrun_o[1]=1; channel 1 is serviced once, with B at eng_sin_o/eng_cos_o.
  - clear_flags_i then drops overrun_o to 0.
- Grant collision: valid_i[3] pulses in the exact IDLE→ISSUE cycle that grants channel 3.
  - Required: the old operands are issued, pend[3] stays set, channel 3 is serviced a second time with the new operands, and overrun_o[3]=0.
- Timeout: engine model never asserts done.
  - Required: timeout_o=1 exactly TIMEOUT_CYCLES cycles after WAIT entry, no valid_o, FSM back in IDLE, and the next pending channel is granted.
  - A late eng_done_i arriving in IDLE causes no valid_o.
- Reset mid-WAIT: assert reset_i for 1 cycle during WAIT.
  - Required: all outputs at their reset values next cycle, pending requests discarded, and no valid_o from the abandoned transaction.

Source files
------------

// File: rtl/cordic_phase_scheduler_if.sv
// rtl/cordic_phase_scheduler_if.sv - channel sample, engine and phase-result signals of the CORDIC phase scheduler
interface cordic_phase_scheduler_if #(
  parameter int NUM_CH        = 4,
  parameter int BIT_WIDTH_IN  = 24,
  parameter int BIT_WIDTH_OUT = 26
);
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]              valid_i;
  logic [NUM_CH*BIT_WIDTH_IN-1:0] sin_i;
  logic [NUM_CH*BIT_WIDTH_IN-1:0] cos_i;
  logic                           clear_flags_i;
  logic                           eng_start_o;
  logic [BIT_WIDTH_IN-1:0]        eng_sin_o;
  logic [BIT_WIDTH_IN-1:0]        eng_cos_o;
  logic [BIT_WIDTH_OUT-1:0]       eng_phi_i;
  logic                           eng_done_i;
  logic [BIT_WIDTH_OUT-1:0]       phi_o;
  logic [CW-1:0]                  ch_o;
  logic                           valid_o;
  logic                           busy_o;
  logic [NUM_CH-1:0]              overrun_o;
  logic                           timeout_o;

  modport slave (
    input  valid_i, sin_i, cos_i, clear_flags_i, eng_phi_i, eng_done_i,
    output eng_start_o, eng_sin_o, eng_cos_o, phi_o, ch_o, valid_o, busy_o,
           overrun_o, timeout_o
  );

  modport master (
    output valid_i, sin_i, cos_i, clear_flags_i, eng_phi_i, eng_done_i,
    input  eng_start_o, eng_sin_o, eng_cos_o, phi_o, ch_o, valid_o, busy_o,
           overrun_o, timeout_o
  );
endinterface

// File: rtl/cordic_phase_scheduler.sv
// rtl/cordic_phase_scheduler.sv - round-robin sharing of one CORDIC phase engine between channels
module cordic_phase_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int BIT_WIDTH_IN   = 24,
  parameter int BIT_WIDTH_OUT  = 26,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  cordic_phase_scheduler_if.slave bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

  state_t                   state, state_nxt;
  logic [NUM_CH-1:0]        pend, grant_clr, ovr_evt, overrun;
  logic [BIT_WIDTH_IN-1:0]  sin_h [NUM_CH];
  logic [BIT_WIDTH_IN-1:0]  cos_h [NUM_CH];
  logic [CW-1:0]            last_grant, win, ch;
  logic [CW:0]              cand;
  logic                     found, grant_fire, timeout, timeout_evt, wait_last;
  logic [TW-1:0]            wait_cnt;
  logic [BIT_WIDTH_IN-1:0]  op_sin, op_cos;
  logic [BIT_WIDTH_OUT-1:0] phi;
  logic                     start, busy, vout;

  // Rotated search: first pending channel after last_grant wins.
  always_comb begin
    win   = last_grant;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = {1'b0, last_grant} + (CW+1)'(i);
      if (cand >= (CW+1)'(NUM_CH)) cand = cand - (CW+1)'(NUM_CH);
      if (!found && pend[cand[CW-1:0]]) begin
        win   = cand[CW-1:0];
        found = 1'b1;
      end
    end
  end

  assign grant_fire  = (state == S_IDLE) && found;
  assign grant_clr   = grant_fire ? (NUM_CH'(1) << win) : '0;
  assign ovr_evt     = bus.valid_i & pend & ~grant_clr;
  assign wait_last   = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_evt = (state == S_WAIT) && !bus.eng_done_i && wait_last;

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.valid_i[k]) begin
        sin_h[k] <= bus.sin_i[k*BIT_WIDTH_IN +: BIT_WIDTH_IN];
        cos_h[k] <= bus.cos_i[k*BIT_WIDTH_IN +: BIT_WIDTH_IN];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (found) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.eng_done_i)  state_nxt = S_OUTPUT;
        else if (wait_last)  state_nxt = S_IDLE;
      end
      S_OUTPUT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    busy  = 1'b0;
    vout  = 1'b0;
    case (state)
      S_ISSUE:  begin start = 1'b1; busy = 1'b1; end
      S_WAIT:   busy = 1'b1;
      S_OUTPUT: vout = 1'b1;
      default:  ;
    endcase
  end

  // A new sample on the granted channel re-arms pend (set wins over grant).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend       <= '0;
      overrun    <= '0;
      timeout    <= 1'b0;
      last_grant <= CW'(NUM_CH - 1);
      op_sin     <= '0;
      op_cos     <= '0;
      phi        <= '0;
      ch         <= '0;
      wait_cnt   <= '0;
    end else begin
      pend    <= (pend & ~grant_clr) | bus.valid_i;
      overrun <= (bus.clear_flags_i ? '0 : overrun) | ovr_evt;
      timeout <= (bus.clear_flags_i ? 1'b0 : timeout) | timeout_evt;
      if (grant_fire) begin
        op_sin     <= sin_h[win];
        op_cos     <= cos_h[win];
        last_grant <= win;
      end
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (state == S_WAIT && bus.eng_done_i) begin
        phi <= bus.eng_phi_i;
        ch  <= last_grant;
      end
    end
  end

  assign bus.eng_start_o = start;
  assign bus.eng_sin_o   = op_sin;
  assign bus.eng_cos_o   = op_cos;
  assign bus.phi_o       = phi;
  assign bus.ch_o        = ch;
  assign bus.valid_o     = vout;
  assign bus.busy_o      = busy;
  assign bus.overrun_o   = overrun;
  assign bus.timeout_o   = timeout;
endmodule

// File: tb/tb_cordic_phase_scheduler.sv
// tb/tb_cordic_phase_scheduler.sv - directed self-checking bench for cordic_phase_scheduler
module tb_cordic_phase_scheduler;
  localparam int NCH = 4;
  localparam int WI  = 24;
  localparam int WO  = 26;
  localparam int TO  = 64;
  localparam int LAT = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_phase_scheduler_if #(.NUM_CH(NCH), .BIT_WIDTH_IN(WI), .BIT_WIDTH_OUT(WO)) bus ();

  cordic_phase_scheduler #(
    .NUM_CH(NCH), .BIT_WIDTH_IN(WI), .BIT_WIDTH_OUT(WO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engine: done in the cycle LAT after the start cycle.
  logic eng_en    = 1'b1;
  logic eng_busy  = 1'b0;
  logic late_done = 1'b0;
  int   eng_el    = 0;
  always @(posedge clk) begin
    if (rst) begin
      eng_busy <= 1'b0;
      eng_el   <= 0;
    end else if (bus.eng_start_o) begin
      eng_busy <= 1'b1;
      eng_el   <= 1;
    end else if (eng_busy) begin
      if (eng_el == LAT) eng_busy <= 1'b0;
      else               eng_el   <= eng_el + 1;
    end
  end
  assign bus.eng_done_i = (eng_en && eng_busy && eng_el == LAT) || late_done;
  assign bus.eng_phi_i  = 26'h12345;

  int            st_cyc [$];
  logic [WI-1:0] st_sin [$];
  logic [WI-1:0] st_cos [$];
  int            vd_cyc [$];
  logic [1:0]    vd_ch  [$];
  logic [WO-1:0] vd_phi [$];
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.eng_start_o) begin
        st_cyc.push_back(cyc);
        st_sin.push_back(bus.eng_sin_o);
        st_cos.push_back(bus.eng_cos_o);
      end
      if (bus.valid_o) begin
        vd_cyc.push_back(cyc);
        vd_ch.push_back(bus.ch_o);
        vd_phi.push_back(bus.phi_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_q();
    st_cyc.delete(); st_sin.delete(); st_cos.delete();
    vd_cyc.delete(); vd_ch.delete();  vd_phi.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.valid_i = '0;
    bus.clear_flags_i = 1'b0;
    late_done = 1'b0;
    eng_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clr_q();
  endtask

  task automatic load(input int k, input logic [WI-1:0] s, input logic [WI-1:0] c);
    bus.valid_i[k] = 1'b1;
    bus.sin_i[k*WI +: WI] = s;
    bus.cos_i[k*WI +: WI] = c;
  endtask

  task automatic strobe();
    tick();
    bus.valid_i = '0;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_valids(input string tag, input int n, input int limit);
    int b = 0;
    while (vd_cyc.size() < n && b < limit) begin
      tick();
      b++;
    end
    chk(tag, vd_cyc.size(), n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " start"},   bus.eng_start_o, 0);
    chk({tag, " sin"},     bus.eng_sin_o, 0);
    chk({tag, " cos"},     bus.eng_cos_o, 0);
    chk({tag, " phi"},     bus.phi_o, 0);
    chk({tag, " ch"},      bus.ch_o, 0);
    chk({tag, " valid"},   bus.valid_o, 0);
    chk({tag, " busy"},    bus.busy_o, 0);
    chk({tag, " overrun"}, bus.overrun_o, 0);
    chk({tag, " timeout"}, bus.timeout_o, 0);
  endtask

  initial begin
    bus.valid_i = '0;
    bus.sin_i = '0;
    bus.cos_i = '0;
    bus.clear_flags_i = 1'b0;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    clr_q();

    // single request on channel 2
    t0 = cyc;
    load(2, 24'd0, 24'd4194304);
    strobe();
    wait_valids("single count", 1, 100);
    chk("single start cycle", st_cyc[0] - t0, 2);
    chk("single start sin", st_sin[0], 24'd0);
    chk("single start cos", st_cos[0], 24'd4194304);
    chk("single valid cycle", vd_cyc[0] - t0, 29);
    chk("single phi", vd_phi[0], 26'h12345);
    chk("single ch", vd_ch[0], 2);

    // round-robin burst, twice
    do_reset();
    for (int k = 0; k < NCH; k++) load(k, 24'(k*16 + 1), 24'(k*16 + 2));
    strobe();
    wait_valids("rr1 count", 4, 200);
    for (int k = 0; k < NCH; k++) begin
      chk("rr1 ch order", vd_ch[k], k);
      chk("rr1 operand", st_sin[k], 24'(k*16 + 1));
    end
    chk("rr1 restart spacing", st_cyc[1] - vd_cyc[0], 2);
    repeat (40) tick();
    chk("rr1 no extra valid", vd_cyc.size(), 4);
    chk("rr1 overrun", bus.overrun_o, 0);
    clr_q();
    for (int k = 0; k < NCH; k++) load(k, 24'(k*16 + 9), 24'(k*16 + 10));
    strobe();
    wait_valids("rr2 count", 4, 200);
    for (int k = 0; k < NCH; k++) begin
      chk("rr2 ch order", vd_ch[k], k);
      chk("rr2 operand", st_cos[k], 24'(k*16 + 10));
    end

    // overrun on channel 1 while channel 0 is in flight
    do_reset();
    t0 = cyc;
    load(0, 24'h000100, 24'h000200);
    strobe();
    tick_to(t0 + 5);
    chk("ovr busy in wait", bus.busy_o, 1);
    load(1, 24'h0000AA, 24'h0000AB);
    strobe();
    load(1, 24'h0000BB, 24'h0000BC);
    strobe();
    chk("ovr flag", bus.overrun_o, 4'b0010);
    wait_valids("ovr count", 2, 200);
    repeat (40) tick();
    chk("ovr serviced once", vd_cyc.size(), 2);
    chk("ovr starts", st_cyc.size(), 2);
    chk("ovr ch", vd_ch[1], 1);
    chk("ovr sin B", st_sin[1], 24'h0000BB);
    chk("ovr cos B", st_cos[1], 24'h0000BC);
    bus.clear_flags_i = 1'b1;
    tick();
    bus.clear_flags_i = 1'b0;
    chk("ovr cleared", bus.overrun_o, 0);

    // new sample on channel 3 in its own grant cycle
    do_reset();
    load(3, 24'h00C001, 24'h00C002);
    strobe();
    load(3, 24'h00D001, 24'h00D002);
    strobe();
    wait_valids("coll count", 2, 200);
    chk("coll first old sin", st_sin[0], 24'h00C001);
    chk("coll second new sin", st_sin[1], 24'h00D001);
    chk("coll second new cos", st_cos[1], 24'h00D002);
    chk("coll ch0", vd_ch[0], 3);
    chk("coll ch1", vd_ch[1], 3);
    chk("coll overrun", bus.overrun_o, 0);

    // engine never answers
    do_reset();
    eng_en = 1'b0;
    t0 = cyc;
    load(0, 24'h000011, 24'h000012);
    load(2, 24'h000022, 24'h000023);
    strobe();
    tick_to(t0 + 66);
    chk("to not yet", bus.timeout_o, 0);
    tick();
    chk("to set", bus.timeout_o, 1);
    chk("to idle", bus.busy_o, 0);
    tick();
    chk("to next start", bus.eng_start_o, 1);
    chk("to next sin", bus.eng_sin_o, 24'h000022);
    tick_to(t0 + 140);
    late_done = 1'b1;
    tick();
    late_done = 1'b0;
    tick();
    tick();
    chk("to no valid", vd_cyc.size(), 0);
    chk("to phi kept", bus.phi_o, 0);
    bus.clear_flags_i = 1'b1;
    tick();
    bus.clear_flags_i = 1'b0;
    chk("to cleared", bus.timeout_o, 0);

    // reset in the middle of WAIT
    do_reset();
    t0 = cyc;
    load(0, 24'h000031, 24'h000032);
    load(1, 24'h000041, 24'h000042);
    strobe();
    tick_to(t0 + 10);
    chk("rst in wait", bus.busy_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    clr_q();
    repeat (100) tick();
    chk("midrst no valid", vd_cyc.size(), 0);
    chk("midrst no start", st_cyc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
